// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 command/response codes, host-tx state encoding and parity helper
package ps2_host_tx_pkg;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RSP_BAT_OK = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RELEASE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_host_tx_line_filter: 2-FF synchronizer, glitch filter and falling-edge detector for a PS/2 line
module ps2_host_tx_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_s1, r_s2, r_level, r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_flip;

    assign w_flip = (r_s2 != r_level) && (r_cnt == CW'(FILTER_LEN - 1));
    assign o_sync = r_s2;
    assign o_fall = r_fall;

    // synchronize, then flip the filtered level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_fall  <= 1'b0;
        end else begin
            r_s1    <= i_line;
            r_s2    <= r_s1;
            r_cnt   <= (r_s2 == r_level || w_flip) ? '0 : r_cnt + CW'(1);
            r_level <= w_flip ? r_s2 : r_level;
            r_fall  <= w_flip && r_level;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter on the shared open-drain clock/data pair
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_busy,
    output logic       o_tx_done,
    output logic       o_tx_err,
    inout  wire        io_ps2_clk,
    inout  wire        io_ps2_data
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state, w_next;
    logic [IW-1:0] r_inh;
    logic [TW-1:0] r_to;
    logic [3:0]    r_n;
    logic [8:0]    r_shift;
    logic          r_data_low, r_d1, r_d2;
    logic          w_clk_sync, w_fall, w_inh_last, w_timeout, w_step, w_clk_oe, w_data_oe;

    ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .i_line(io_ps2_clk),
        .o_sync(w_clk_sync),
        .o_fall(w_fall)
    );

    assign w_inh_last = r_inh == IW'(INHIBIT_CYCLES - 1);
    assign w_timeout  = r_to == TW'(TIMEOUT_CYCLES - 1);
    assign w_step     = r_state == ST_SEND && w_fall && !w_timeout;

    assign io_ps2_clk  = w_clk_oe  ? 1'b0 : 1'bz;
    assign io_ps2_data = w_data_oe ? 1'b0 : 1'bz;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // next-state logic; a timeout outranks a fall seen in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      w_next = i_tx_valid ? ST_INHIBIT : ST_IDLE;
            ST_INHIBIT:   w_next = w_inh_last ? ST_RELEASE : ST_INHIBIT;
            ST_RELEASE:   w_next = ST_SEND;
            ST_SEND:      w_next = w_timeout ? ST_ERR : (w_fall && r_n == 4'd9) ? ST_WAIT_ACK : ST_SEND;
            ST_WAIT_ACK:  w_next = w_timeout ? ST_ERR : !w_fall ? ST_WAIT_ACK : r_d2 ? ST_ERR : ST_WAIT_IDLE;
            ST_WAIT_IDLE: w_next = w_timeout ? ST_ERR : (w_clk_sync && r_d2) ? ST_DONE : ST_WAIT_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    // outputs and open-drain enables decoded from state
    always_comb begin
        o_tx_ready = r_state == ST_IDLE;
        o_busy     = !(r_state inside {ST_IDLE, ST_DONE, ST_ERR});
        o_tx_done  = r_state == ST_DONE;
        o_tx_err   = r_state == ST_ERR;
        w_clk_oe   = r_state == ST_INHIBIT;
        w_data_oe  = (r_state == ST_INHIBIT && w_inh_last) || r_state == ST_RELEASE ||
                     (r_state == ST_SEND && r_data_low);
    end

    // frame datapath: counters, shift register, data-line drive and data synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inh      <= '0;
            r_to       <= '0;
            r_n        <= '0;
            r_shift    <= '0;
            r_data_low <= 1'b0;
            r_d1       <= 1'b1;
            r_d2       <= 1'b1;
        end else begin
            r_d1       <= io_ps2_data;
            r_d2       <= r_d1;
            r_inh      <= (r_state == ST_INHIBIT) ? r_inh + IW'(1) : '0;
            r_to       <= (r_state == ST_RELEASE) ? TW'(1) :
                          (r_state inside {ST_SEND, ST_WAIT_ACK, ST_WAIT_IDLE}) ? r_to + TW'(1) : '0;
            r_n        <= (r_state == ST_RELEASE) ? 4'd0 : w_step ? r_n + 4'd1 : r_n;
            r_shift    <= (r_state == ST_IDLE && i_tx_valid) ? {odd_parity(i_tx_data), i_tx_data} :
                          w_step ? {1'b0, r_shift[8:1]} : r_shift;
            r_data_low <= (r_state == ST_RELEASE) ? 1'b1 :
                          (r_state != ST_SEND) ? 1'b0 :
                          w_step ? (r_n <= 4'd8 && !r_shift[0]) : r_data_low;
        end
    end

endmodule
